// File: rtl/tinyqv_mem_pkg.sv
// Shared definitions for the tinyQV memory arbiter: FSM state codes,
// transfer size encodings and default widths.
package tinyqv_mem_pkg;

    localparam int ADDR_W_DEFAULT          = 24;
    localparam int MAX_DATA_STREAK_DEFAULT = 3;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_INSTR = 2'd1;
    localparam arb_state_t ST_DATA  = 2'd2;
    localparam arb_state_t ST_ABORT = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/tinyqv_streak_counter.sv
// Saturating count of consecutive data grants made while a fetch waits.
// clr has priority over inc; the count sticks at MAX once reached.
module tinyqv_streak_counter #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/tinyqv_mem_arbiter.sv
// Shares one QSPI controller between the instruction-fetch and load/store ports.
// Handshake: a requester holds req and its payload stable until it sees a one-cycle ack; a req seen while its own ack is high is the old request and is ignored.
module tinyqv_mem_arbiter
    import tinyqv_mem_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEFAULT,
    parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_abort,
    output logic              instr_ack,
    output logic [31:0]       instr_rdata,

    input  logic              data_req,
    input  logic              data_write,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_ack,
    output logic [31:0]       data_rdata,

    output logic              mem_start,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_stop,
    input  logic              mem_done,
    input  logic [31:0]       mem_rdata,

    output logic              grant_data,
    output logic [1:0]        dbg_state
);

    arb_state_t state;

    logic instr_elig;
    logic data_elig;
    logic grant_d;
    logic grant_i;
    logic streak_inc;
    logic streak_clr;
    logic streak_at_max;

    assign instr_elig = instr_req && !instr_ack;
    assign data_elig  = data_req && !data_ack;

    // Data wins a tie unless it has already starved a waiting fetch long enough.
    assign grant_d = (state == ST_IDLE) && data_elig && (!instr_elig || !streak_at_max);
    assign grant_i = (state == ST_IDLE) && instr_elig && !grant_d;

    assign streak_inc = grant_d && instr_req;
    assign streak_clr = grant_i || (grant_d && !instr_req);

    tinyqv_streak_counter #(
        .MAX (MAX_DATA_STREAK)
    ) u_streak (
        .clk    (clk),
        .rst    (rst),
        .inc    (streak_inc),
        .clr    (streak_clr),
        .at_max (streak_at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_start   <= 1'b0;
            mem_stop    <= 1'b0;
            mem_write   <= 1'b0;
            mem_size    <= 2'd0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr_ack   <= 1'b0;
            instr_rdata <= '0;
            data_ack    <= 1'b0;
            data_rdata  <= '0;
        end else begin
            mem_start <= 1'b0;
            mem_stop  <= 1'b0;
            instr_ack <= 1'b0;
            data_ack  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        mem_start <= 1'b1;
                        mem_write <= data_write;
                        mem_size  <= data_size;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_wdata;
                        state     <= ST_DATA;
                    end else if (grant_i) begin
                        mem_start <= 1'b1;
                        mem_write <= 1'b0;
                        mem_size  <= SIZE_WORD;
                        mem_addr  <= instr_addr;
                        state     <= ST_INSTR;
                    end
                end

                ST_INSTR: begin
                    // An abort landing with the completion simply drops the word.
                    if (mem_done) begin
                        if (!instr_abort) begin
                            instr_ack   <= 1'b1;
                            instr_rdata <= mem_rdata;
                        end
                        state <= ST_IDLE;
                    end else if (instr_abort) begin
                        mem_stop <= 1'b1;
                        state    <= ST_ABORT;
                    end
                end

                ST_DATA: begin
                    if (mem_done) begin
                        data_ack <= 1'b1;
                        if (!mem_write) begin
                            data_rdata <= mem_rdata;
                        end
                        state <= ST_IDLE;
                    end
                end

                ST_ABORT: begin
                    if (mem_done) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign grant_data = (state == ST_DATA);
    assign dbg_state  = state;

endmodule
